sparc_mem_ctrl: RTL
===================

// Module: sparc_mem_ctrl
// PURPOSE
//   Byte-addressable, big-endian main memory with a MOV/MOC four-phase handshake. Sits directly
//   downstream of the SPARC MPU: consumes the datapath's MAR, MDR, r_w, mov and type signals and
//   returns read data plus MOC, which the control unit waits on in its memory states.
//   Access latency is fixed and programmable, to exercise the control unit's wait loops.
// PARAMETERS
//   ADDR_W   9   memory address bits; depth = 2**ADDR_W bytes; upper Addr bits ignored
//   LATENCY  2   cycles from the MOV-sampling edge to MOC assertion; legal range 1..15
// PORTS
//   Clk      in   1   system clock, rising edge
//   Clr      in   1   asynchronous, active-high reset
//   MOV      in   1   memory operation valid, held high until MOC seen
//   R_W      in   1   1 = read, 0 = write
//   Type     in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   Addr     in   32  byte address (from MAR)
//   DataIn   in   32  write data (from MDR), right-justified for byte/half
//   DataOut  out  32  read data, zero-extended, right-justified
//   MOC      out  1   memory operation complete
//   AlignErr out  1   access rejected (misaligned or Type=11); valid while MOC=1
// BEHAVIOUR
//   Reset (Clr=1, async): state IDLE, MOC=0, DataOut=0, AlignErr=0, counter=0.
//     Memory array is not reset.
//   FSM: IDLE -> WAIT -> DONE -> IDLE, all transitions on rising Clk.
//   IDLE: MOV=1 sampled at edge N -> latch Addr[ADDR_W-1:0], R_W, Type, DataIn; cnt=LATENCY-1; WAIT.
//     Later changes on inputs do not affect the operation in flight.
//   WAIT: cnt!=0 -> cnt-1. cnt==0 -> perform the access, go to DONE, MOC=1 (first high after edge N+LATENCY).
//   DONE: MOC=1; DataOut/AlignErr held. MOV=0 sampled -> IDLE, MOC=0, AlignErr=0 at that edge.
//     While MOV stays 1, remain in DONE (no re-trigger); a new op needs MOV low for >=1 edge.
//   MOV dropped during WAIT: operation still completes, DONE entered, MOC high exactly one cycle.
//   Alignment: half requires a[0]=0; word requires a[1:0]=00; Type=11 always illegal.
//     Illegal access: no array write, DataOut=0, AlignErr=1 with MOC.
//   Big-endian; a = latched address:
//     read byte  DataOut={24'b0,m[a]}
//     read half  DataOut={16'b0,m[a],m[a+1]}
//     read word  {m[a],m[a+1],m[a+2],m[a+3]}
//     write byte m[a]=DataIn[7:0]; half writes DataIn[15:0]; word writes DataIn[31:0] (MSB at a).
//   Writes leave DataOut unchanged. Sign extension is the datapath's job, not this block's.
//   Address wrap: Addr modulo 2**ADDR_W; an aligned access never crosses the top of the array.
//   Commit point: array write and DataOut update happen only on the WAIT->DONE edge.
//     Clr asserted earlier aborts with no memory change; Clr in DONE drops MOC immediately.
//   No back-to-back overlap: at most one operation in flight; MOV ignored outside IDLE.
// TESTING
//   1 Reset: Clr=1 mid-WAIT of a word write to 0x10 -> MOC=0 at once, m[0x10..0x13] unchanged,
//     DataOut=0.
//   2 Latency: LATENCY=2, word write 0xDEADBEEF @0x20 sampled at edge N -> MOC=1 after edge N+2,
//     not before; MOV low -> MOC=0 next edge.
//   3 Endianness: after test 2, byte read @0x20 -> 0x000000DE; half read @0x22 -> 0x0000BEEF;
//     word read @0x20 -> 0xDEADBEEF.
//   4 Partial write: byte write 0x5A @0x21 then word read @0x20 -> 0xDE5ABEEF; half write 0x1234
//     @0x22 -> 0xDE5A1234.
//   5 Misalign: word read @0x22 and half read @0x21 -> MOC=1, AlignErr=1, DataOut=0; Type=11 write
//     @0x20 -> AlignErr=1, memory unchanged.
//   6 Handshake edges: MOV held high 10 cycles in DONE -> single op, MOC stays 1.
//     MOV dropped in WAIT -> one-cycle MOC pulse. Addr=0x1000_0024 aliases to 0x024 (ADDR_W=9).

Source files
------------

// File: rtl/sparc_mem_ctrl_if.sv
// sparc_mem_ctrl_if: MOV/MOC memory bus between the SPARC datapath and main memory
interface sparc_mem_ctrl_if;
  logic        mov;
  logic        r_w;
  logic [1:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        align_err;
  modport master (output mov, r_w, mem_type, addr, data_in, input data_out, moc, align_err);
  modport slave (input mov, r_w, mem_type, addr, data_in, output data_out, moc, align_err);
endinterface

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: big-endian byte memory with fixed-latency MOV/MOC four-phase handshake
module sparc_mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  sparc_mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] a, a1, a2, a3;
  logic rw;
  logic [1:0] ty;
  logic [31:0] din, dout, rd;
  logic err, bad, commit;
  logic [7:0] m [2**ADDR_W];
  assign a1 = a + ADDR_W'(1);
  assign a2 = a + ADDR_W'(2);
  assign a3 = a + ADDR_W'(3);
  assign bad = ty == 2'b11 || (ty == 2'b01 && a[0]) || (ty == 2'b10 && |a[1:0]);
  assign commit = state == WAIT && cnt == 4'd0;
  assign rd = ty == 2'b00 ? {24'b0, m[a]} :
              ty == 2'b01 ? {16'b0, m[a], m[a1]} : {m[a], m[a1], m[a2], m[a3]};
  assign bus.data_out = dout;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: one op per MOV rise, DONE held until MOV drops
  always_comb
    state_nx = state == IDLE ? (bus.mov ? WAIT : IDLE) :
               state == WAIT ? (cnt == 4'd0 ? DONE : WAIT) :
               (bus.mov ? DONE : IDLE);
  // outputs: MOC and AlignErr only while DONE
  always_comb begin
    bus.moc = state == DONE;
    bus.align_err = state == DONE && err;
  end
  // capture the request on acceptance and count down the latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 4'd0;
      a <= '0;
      rw <= 1'b0;
      ty <= 2'b00;
      din <= 32'd0;
    end else if (state == IDLE && bus.mov) begin
      cnt <= 4'(LATENCY - 1);
      a <= bus.addr[ADDR_W-1:0];
      rw <= bus.r_w;
      ty <= bus.mem_type;
      din <= bus.data_in;
    end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  // read data and error flag update only on the commit edge; writes keep old data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= 32'd0;
      err <= 1'b0;
    end else if (commit) begin
      err <= bad;
      if (bad || rw) dout <= bad ? 32'd0 : rd;
    end
  // array write on the commit edge; contents survive reset
  always_ff @(posedge clk)
    if (commit && !rw && !bad) begin
      if (ty == 2'b00) m[a] <= din[7:0];
      if (ty == 2'b01) begin
        m[a] <= din[15:8];
        m[a1] <= din[7:0];
      end
      if (ty == 2'b10) begin
        m[a] <= din[31:24];
        m[a1] <= din[23:16];
        m[a2] <= din[15:8];
        m[a3] <= din[7:0];
      end
    end
endmodule
